// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   icache_size_log_default : log2 of the number of one-word lines
//   state_e                 : controller state (idle / waiting on a line fill)
package icache_pkg;

  localparam int unsigned IcacheSizeLogDefault = 8;

  typedef enum logic [0:0] {
    StIdle,
    StMiss
  } state_e;

  // Tag covers the word address bits above the index.
  function automatic int unsigned tag_width(input int unsigned size_log);
    return 30 - size_log;
  endfunction

endpackage

// File: rtl/icache_array.sv
// Storage for the instruction cache: valid bits, tags and one 32-bit word per line.
//   clk_i, rst_i  : clock, synchronous active-high reset (clears valid bits only)
//   rd_word_i     : word address (byte address [31:2]) looked up combinationally
//   rd_hit_o      : line valid and tag matches
//   rd_data_o     : data word of the indexed line
//   wr_en_i       : fill the line addressed by wr_word_i with wr_data_i
module icache_array
  import icache_pkg::*;
#(
  parameter int unsigned SizeLog  = IcacheSizeLogDefault,
  parameter int unsigned TagWidth = 30 - SizeLog
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [29:0] rd_word_i,
  output logic        rd_hit_o,
  output logic [31:0] rd_data_o,
  input  logic        wr_en_i,
  input  logic [29:0] wr_word_i,
  input  logic [31:0] wr_data_i
);

  localparam int unsigned Lines = 1 << SizeLog;

  logic [Lines-1:0]    valid_q;
  logic [TagWidth-1:0] tag_q  [Lines];
  logic [31:0]         data_q [Lines];

  logic [SizeLog-1:0]  rd_idx;
  logic [TagWidth-1:0] rd_tag;
  logic [SizeLog-1:0]  wr_idx;
  logic [TagWidth-1:0] wr_tag;

  assign rd_idx = rd_word_i[SizeLog-1:0];
  assign rd_tag = rd_word_i[29:SizeLog];
  assign wr_idx = wr_word_i[SizeLog-1:0];
  assign wr_tag = wr_word_i[29:SizeLog];

  assign rd_hit_o  = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
  assign rd_data_o = data_q[rd_idx];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag and data need no reset: a line is only read through its valid bit.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data_i;
    end
  end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between the fetch stage and the memory controller.
// Hits answer one cycle after the request; misses issue a word read to memory, fill the
// line and forward the word.
//   clk, rst           : clock, synchronous active-high reset
//   rdy                : global ready, everything frozen while low
//   jump_rst           : misprediction flush, abandons any outstanding miss
//   IF_valid, IF_addr  : fetch request pulse and word-aligned PC
//   IF_send, IF_inst   : one-cycle response pulse and instruction
//   mem_send, mem_addr : read request level and address towards memory
//   mem_valid, mem_val : one-cycle read response pulse and data word
module icache
  import icache_pkg::*;
#(
  parameter int unsigned ICACHE_SIZE_LOG = IcacheSizeLogDefault,
  parameter int unsigned TAG_WIDTH       = tag_width(ICACHE_SIZE_LOG)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_rst,
  input  logic        IF_valid,
  input  logic [31:0] IF_addr,
  output logic        IF_send,
  output logic [31:0] IF_inst,
  output logic        mem_send,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_val
);

  state_e      state_q, state_d;
  logic        if_send_q, if_send_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        mem_send_q, mem_send_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic        rd_hit;
  logic [31:0] rd_data;
  logic        fill_en;

  // Byte offset is always zero for fetches and memory requests.
  logic unused_low_bits;
  assign unused_low_bits = ^{IF_addr[1:0], mem_addr_q[1:0]};

  icache_array #(
    .SizeLog  (ICACHE_SIZE_LOG),
    .TagWidth (TAG_WIDTH)
  ) u_array (
    .clk_i     (clk),
    .rst_i     (rst),
    .rd_word_i (IF_addr[31:2]),
    .rd_hit_o  (rd_hit),
    .rd_data_o (rd_data),
    .wr_en_i   (fill_en),
    .wr_word_i (mem_addr_q[31:2]),
    .wr_data_i (mem_val)
  );

  always_comb begin
    state_d    = state_q;
    if_send_d  = if_send_q;
    if_inst_d  = if_inst_q;
    mem_send_d = mem_send_q;
    mem_addr_d = mem_addr_q;
    fill_en    = 1'b0;

    if (rdy) begin
      if_send_d = 1'b0;
      if (jump_rst) begin
        state_d    = StIdle;
        mem_send_d = 1'b0;
        // A word arriving with the flush is still correct for its address.
        fill_en    = (state_q == StMiss) && mem_valid;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (IF_valid) begin
              if (rd_hit) begin
                if_send_d = 1'b1;
                if_inst_d = rd_data;
              end else begin
                mem_send_d = 1'b1;
                mem_addr_d = IF_addr;
                state_d    = StMiss;
              end
            end
          end
          StMiss: begin
            if (mem_valid) begin
              fill_en    = 1'b1;
              if_send_d  = 1'b1;
              if_inst_d  = mem_val;
              mem_send_d = 1'b0;
              state_d    = StIdle;
            end
          end
          default: state_d = StIdle;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      if_send_q  <= 1'b0;
      if_inst_q  <= '0;
      mem_send_q <= 1'b0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      if_send_q  <= if_send_d;
      if_inst_q  <= if_inst_d;
      mem_send_q <= mem_send_d;
      mem_addr_q <= mem_addr_d;
    end
  end

  assign IF_send  = if_send_q;
  assign IF_inst  = if_inst_q;
  assign mem_send = mem_send_q;
  assign mem_addr = mem_addr_q;

endmodule
